// File: rtl/window_median_engine_pkg.sv
// Shared encodings and sizing for the 3x3 window median engine.
package window_median_engine_pkg;

    localparam int unsigned WINDOW_LEN = 9;
    localparam int unsigned MEDIAN_IDX = 4;
    localparam int unsigned COUNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } engine_state_t;

endpackage

// File: rtl/window_median_engine_if.sv
// Pixel-in / median-out handshake bundle for window_median_engine.
interface window_median_engine_if #(
    parameter int unsigned PIXEL_WIDTH = 8
);
    import window_median_engine_pkg::*;

    logic [PIXEL_WIDTH-1:0] pixIn;
    logic                   pixValid;
    logic                   windowStart;
    logic                   pixReady;
    logic [PIXEL_WIDTH-1:0] medianOut;
    logic                   medianValid;
    logic                   medianReady;

    modport master (
        output pixIn, pixValid, windowStart, medianReady,
        input  pixReady, medianOut, medianValid
    );

    modport slave (
        input  pixIn, pixValid, windowStart, medianReady,
        output pixReady, medianOut, medianValid
    );

endinterface

// File: rtl/window_median_engine_sort_insert_stage.sv
// One slot of the insertion sorter: hold, take the new pixel, or take the left neighbour.
module sort_insert_stage
    import window_median_engine_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8
) (
    input  logic [PIXEL_WIDTH-1:0] pixIn,
    input  logic [PIXEL_WIDTH-1:0] leftVal,
    input  logic                   leftValid,
    input  logic [PIXEL_WIDTH-1:0] slotVal,
    input  logic                   slotValid,
    output logic [PIXEL_WIDTH-1:0] slotNext_c
);

    logic leftMoves;
    logic selfMoves;

    // An entry yields its place when empty or strictly greater, so equal entries stay ahead of the new pixel.
    assign leftMoves = !leftValid || (leftVal > pixIn);
    assign selfMoves = !slotValid || (slotVal > pixIn);

    always_comb begin
        slotNext_c = slotVal;
        if (leftMoves) begin
            slotNext_c = leftVal;
        end else if (selfMoves) begin
            slotNext_c = pixIn;
        end
    end

endmodule

// File: rtl/window_median_engine.sv
// Streaming 9-pixel median: insertion-sorts each window, then offers sorted[4].
// Optional MEDIAN_MINMAX_EN adds minOut/maxOut registered alongside the median.
module window_median_engine #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned WINDOW_LEN  = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    window_median_engine_if.slave  pixBus,
`ifdef MEDIAN_MINMAX_EN
    output logic [PIXEL_WIDTH-1:0] minOut,
    output logic [PIXEL_WIDTH-1:0] maxOut,
`endif
    output logic                   busy
);
    import window_median_engine_pkg::*;

    engine_state_t          state;
    engine_state_t          stateNext;
    logic [COUNT_W-1:0]     count;
    logic [PIXEL_WIDTH-1:0] sorted     [WINDOW_LEN];
    logic [PIXEL_WIDTH-1:0] sortedNext [WINDOW_LEN];

    logic accept;
    logic acceptStart;
    logic acceptInsert;
    logic loadMedian;
    logic releaseMedian;

    // Next-state and control decode.
    always_comb begin
        stateNext     = state;
        accept        = pixBus.pixValid && pixBus.pixReady;
        acceptStart   = 1'b0;
        acceptInsert  = 1'b0;
        loadMedian    = 1'b0;
        releaseMedian = 1'b0;
        case (state)
            IDLE: begin
                if (accept && pixBus.windowStart) begin
                    acceptStart = 1'b1;
                    stateNext   = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (pixBus.windowStart) begin
                        acceptStart = 1'b1;
                    end else begin
                        acceptInsert = 1'b1;
                        if (count == COUNT_W'(WINDOW_LEN - 1)) begin
                            stateNext = OUTPUT;
                        end
                    end
                end
            end
            OUTPUT: begin
                if (!pixBus.medianValid) begin
                    loadMedian = 1'b1;
                end else if (pixBus.medianReady) begin
                    releaseMedian = 1'b1;
                    stateNext     = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register with ready/busy decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            pixBus.pixReady <= 1'b1;
            busy            <= 1'b0;
        end else begin
            state           <= stateNext;
            pixBus.pixReady <= (stateNext != OUTPUT);
            busy            <= (stateNext != IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (acceptStart) begin
            count <= COUNT_W'(1);
        end else if (acceptInsert) begin
            count <= count + COUNT_W'(1);
        end else if (releaseMedian) begin
            count <= '0;
        end
    end

    // Slot 0 sees a pinned neighbour that never yields, so it only holds or takes the new pixel.
    for (genvar i = 0; i < WINDOW_LEN; i++) begin : gSlot
        logic [PIXEL_WIDTH-1:0] leftVal;
        logic                   leftValid;
        if (i == 0) begin : gHead
            assign leftVal   = '0;
            assign leftValid = 1'b1;
        end else begin : gBody
            assign leftVal   = sorted[i-1];
            assign leftValid = (COUNT_W'(i - 1) < count);
        end
        sort_insert_stage #(
            .PIXEL_WIDTH (PIXEL_WIDTH)
        ) uStage (
            .pixIn      (pixBus.pixIn),
            .leftVal    (leftVal),
            .leftValid  (leftValid),
            .slotVal    (sorted[i]),
            .slotValid  (COUNT_W'(i) < count),
            .slotNext_c (sortedNext[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WINDOW_LEN; i++) begin
                sorted[i] <= '0;
            end
        end else if (acceptStart) begin
            sorted[0] <= pixBus.pixIn;
        end else if (acceptInsert) begin
            for (int unsigned i = 0; i < WINDOW_LEN; i++) begin
                sorted[i] <= sortedNext[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixBus.medianOut   <= '0;
            pixBus.medianValid <= 1'b0;
        end else if (loadMedian) begin
            pixBus.medianOut   <= sorted[MEDIAN_IDX];
            pixBus.medianValid <= 1'b1;
        end else if (releaseMedian) begin
            pixBus.medianValid <= 1'b0;
        end
    end

`ifdef MEDIAN_MINMAX_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            minOut <= '0;
            maxOut <= '0;
        end else if (loadMedian) begin
            minOut <= sorted[0];
            maxOut <= sorted[WINDOW_LEN-1];
        end
    end
`endif

endmodule

// File: tb/tb_window_median_engine.sv
// Directed bench for window_median_engine; min/max checks follow MEDIAN_MINMAX_EN.
module tb_window_median_engine;

    logic clk;
    logic reset;
    logic busy;
`ifdef MEDIAN_MINMAX_EN
    logic [7:0] minOut;
    logic [7:0] maxOut;
`endif

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] win [9];

    window_median_engine_if #(.PIXEL_WIDTH(8)) pixBus ();

    window_median_engine #(
        .PIXEL_WIDTH (8),
        .WINDOW_LEN  (9)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pixBus (pixBus),
`ifdef MEDIAN_MINMAX_EN
        .minOut (minOut),
        .maxOut (maxOut),
`endif
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendPixel(input logic [7:0] v, input logic start);
        pixBus.pixIn       = v;
        pixBus.pixValid    = 1'b1;
        pixBus.windowStart = start;
        step();
        pixBus.pixValid    = 1'b0;
        pixBus.windowStart = 1'b0;
    endtask

    task automatic runWindow(input logic [7:0] vals [9], input logic [7:0] expMed,
                             input logic [7:0] expMin, input logic [7:0] expMax, input string tag);
        int c;
        for (int i = 0; i < 9; i++) sendPixel(vals[i], i == 0);
        c = 0;
        while (!pixBus.medianValid && c < 4) begin
            step();
            c++;
        end
        checkVal({tag, "_valid"}, 32'(pixBus.medianValid), 32'd1);
        checkVal({tag, "_median"}, 32'(pixBus.medianOut), 32'(expMed));
`ifdef MEDIAN_MINMAX_EN
        checkVal({tag, "_min"}, 32'(minOut), 32'(expMin));
        checkVal({tag, "_max"}, 32'(maxOut), 32'(expMax));
`else
        if (expMin > expMax) $display("note %s: min above max in vector", tag);
`endif
        step();
        checkVal({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b0;
        pixBus.pixIn       = '0;
        pixBus.pixValid    = 1'b0;
        pixBus.windowStart = 1'b0;
        pixBus.medianReady = 1'b1;
        repeat (2) step();
        checkVal("rst_valid", 32'(pixBus.medianValid), 32'd0);
        checkVal("rst_median", 32'(pixBus.medianOut), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_ready", 32'(pixBus.pixReady), 32'd1);
        checkVal("rst_count", 32'(dut.count), 32'd0);
        reset = 1'b1;
        step();

        // Descending 9..1: exact one-cycle latency after the last accept.
        win = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 0; i < 9; i++) sendPixel(win[i], i == 0);
        checkVal("lat0_valid", 32'(pixBus.medianValid), 32'd0);
        checkVal("lat0_busy", 32'(busy), 32'd1);
        checkVal("lat0_ready", 32'(pixBus.pixReady), 32'd0);
        step();
        checkVal("lat1_valid", 32'(pixBus.medianValid), 32'd1);
        checkVal("lat1_median", 32'(pixBus.medianOut), 32'd5);
        step();
        checkVal("done_valid", 32'(pixBus.medianValid), 32'd0);
        checkVal("done_busy", 32'(busy), 32'd0);
        checkVal("done_ready", 32'(pixBus.pixReady), 32'd1);

        // Extremes alternating, 128 lands in the middle.
        win = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128};
        runWindow(win, 8'd128, 8'd0, 8'd255, "alt");

        // Partial window of five is discarded by a fresh windowStart.
        win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 5; i++) sendPixel(win[i], i == 0);
        checkVal("partial_valid", 32'(pixBus.medianValid), 32'd0);
        checkVal("partial_count", 32'(dut.count), 32'd5);
        checkVal("partial_busy", 32'(busy), 32'd1);
        win = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10};
        runWindow(win, 8'd10, 8'd10, 8'd10, "restart");

        // Restart when one pixel short of a full window.
        for (int i = 0; i < 8; i++) sendPixel(8'd200, i == 0);
        checkVal("full8_count", 32'(dut.count), 32'd8);
        checkVal("full8_valid", 32'(pixBus.medianValid), 32'd0);
        win = '{8'd4, 8'd2, 8'd6, 8'd8, 8'd1, 8'd3, 8'd5, 8'd9, 8'd7};
        runWindow(win, 8'd5, 8'd1, 8'd9, "restart8");

        // Back-pressure: median holds and no pixel is consumed.
        pixBus.medianReady = 1'b0;
        win = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd5, 8'd2, 8'd8, 8'd4, 8'd6};
        for (int i = 0; i < 9; i++) sendPixel(win[i], i == 0);
        step();
        checkVal("hold_valid0", 32'(pixBus.medianValid), 32'd1);
        pixBus.pixIn       = 8'd200;
        pixBus.pixValid    = 1'b1;
        pixBus.windowStart = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checkVal("hold_median", 32'(pixBus.medianOut), 32'd5);
            checkVal("hold_valid", 32'(pixBus.medianValid), 32'd1);
            checkVal("hold_ready", 32'(pixBus.pixReady), 32'd0);
        end
        checkVal("hold_count", 32'(dut.count), 32'd9);
        checkVal("hold_busy", 32'(busy), 32'd1);
        pixBus.pixValid    = 1'b0;
        pixBus.windowStart = 1'b0;
        pixBus.medianReady = 1'b1;
        step();
        checkVal("release_valid", 32'(pixBus.medianValid), 32'd0);
        checkVal("release_busy", 32'(busy), 32'd0);
        checkVal("release_ready", 32'(pixBus.pixReady), 32'd1);

        // Reset in the middle of a window abandons it.
        for (int i = 0; i < 6; i++) sendPixel(8'(i + 1), i == 0);
        reset = 1'b0;
        #1;
        checkVal("midrst_valid", 32'(pixBus.medianValid), 32'd0);
        checkVal("midrst_busy", 32'(busy), 32'd0);
        checkVal("midrst_count", 32'(dut.count), 32'd0);
        checkVal("midrst_ready", 32'(pixBus.pixReady), 32'd1);
        step();
        reset = 1'b1;
        step();
        win = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        runWindow(win, 8'd5, 8'd1, 8'd9, "postrst");

        // A stray pixel in IDLE without windowStart is dropped.
        sendPixel(8'd77, 1'b0);
        checkVal("drop_busy", 32'(busy), 32'd0);
        checkVal("drop_count", 32'(dut.count), 32'd0);
        win = '{8'd50, 8'd10, 8'd90, 8'd30, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60};
        runWindow(win, 8'd50, 8'd10, 8'd90, "drop");

        // Duplicate values.
        win = '{8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd9};
        runWindow(win, 8'd5, 8'd1, 8'd9, "dups");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
